// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared definitions for the inverse AES-128 key schedule: FSM states, RCON table,
// and the byte S-box used by the key step.
package aes_inv_key_schedule_pkg;

  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Byte 0 of the S-box sits in the top eight bits, so entry b lives at 8*(255-b).
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subRot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_key_step.sv
// One combinational AES-128 key schedule step, forward (round r-1 -> r) or
// inverse (round r -> r-1), selected by inv.
module aes_key_step
  import aes_inv_key_schedule_pkg::*;
#(
  parameter int SHARE_SBOX = 1
) (
  input  logic [127:0] key_in,
  input  logic [3:0]   rnd,
  input  logic         inv,
  output logic [127:0] key_out
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_v1, w_v2, w_v3;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = key_in;

  // The inverse step must first recover the previous w3 before it can feed the S-boxes.
  assign w_v3 = w_w3 ^ w_w2;
  assign w_v2 = w_w2 ^ w_w1;
  assign w_v1 = w_w1 ^ w_w0;

  generate
    if (SHARE_SBOX != 0) begin : g_shared
      logic [31:0] w_src;
      assign w_src = inv ? w_v3 : w_w3;
      assign w_t   = subRot(w_src) ^ {rcon(rnd), 24'h000000};
    end else begin : g_dual
      logic [31:0] w_tFwd, w_tInv;
      assign w_tFwd = subRot(w_w3) ^ {rcon(rnd), 24'h000000};
      assign w_tInv = subRot(w_v3) ^ {rcon(rnd), 24'h000000};
      assign w_t    = inv ? w_tInv : w_tFwd;
    end
  endgenerate

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign key_out = inv ? {w_n0, w_v1, w_v2, w_v3} : {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Streams AES-128 round keys 10 down to 0, starting from either the cipher key
// (expanded forward first) or the final round key.
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
#(
  parameter int SHARE_SBOX = 1,
  parameter int NR         = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic         in_is_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic         busy
);

  generate
    if (NR != 10) begin : g_nrCheck
      $error("aes_inv_key_schedule: only NR=10 (AES-128) is supported");
    end
  endgenerate

  state_t         r_state;
  logic [127:0]   r_cur;
  logic [3:0]     r_round;
  logic           r_inReady, r_outValid, r_outLast, r_busy;
  logic [127:0]   w_stepKey;
  logic [3:0]     w_stepRnd;
  logic           w_stepInv;

  // Forward steps produce round+1; inverse steps undo the current round.
  assign w_stepInv = (r_state == ST_EMIT);
  assign w_stepRnd = w_stepInv ? r_round : r_round + 4'd1;

  aes_key_step #(.SHARE_SBOX(SHARE_SBOX)) u_step (
    .key_in (r_cur),
    .rnd    (w_stepRnd),
    .inv    (w_stepInv),
    .key_out(w_stepKey)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_round    <= 4'd0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cur     <= in_key;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            if (in_is_last) begin
              r_round    <= 4'd10;
              r_state    <= ST_EMIT;
              r_outValid <= 1'b1;
            end else begin
              r_round <= 4'd0;
              r_state <= ST_FWD;
            end
          end
        end
        ST_FWD: begin
          r_cur   <= w_stepKey;
          r_round <= r_round + 4'd1;
          if (r_round == 4'd9) begin
            r_state    <= ST_EMIT;
            r_outValid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (r_round != 4'd0) begin
              r_cur     <= w_stepKey;
              r_round   <= r_round - 4'd1;
              r_outLast <= (r_round == 4'd1);
            end else begin
              r_state    <= ST_IDLE;
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
              r_busy     <= 1'b0;
              r_inReady  <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_outLast  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_key   = r_cur;
  assign out_round = r_round;
  assign out_last  = r_outLast;
  assign busy      = r_busy;

endmodule
